piso_tx: RTL

Parallel-in serial-out transmitter: accepts WIDTH-bit words over a valid/ready handshake and shifts each word out one bit per clock with a bit-valid and end-of-word strobe. It is the serialising counterpart to the team's parallel register blocks (pipo/sipo family) and drives a single-wire serial link. A one-word holding register lets a new word be accepted while the current one is shifting, so consecutive words stream with no idle gap.

---
 rtl/piso_tx_if.sv | 23 ++
 rtl/piso_tx.sv | 79 +++++++
 2 files changed

// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle for piso_tx: the word producer is the master
// and the transmitter is the slave.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] pin;
    logic             pin_valid;
    logic             pin_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             busy;

    modport master (
        output pin, pin_valid,
        input  pin_ready, sout, sout_valid, sout_last, busy
    );

    modport slave (
        input  pin, pin_valid,
        output pin_ready, sout, sout_valid, sout_last, busy
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter. A one-word holding register lets the next
// word be accepted while the current word shifts, so back-to-back words stream gap-free.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    piso_tx_if.slave  tx
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic             last_bit;

    assign tx.pin_ready = !hold_full_q && !rst;
    assign accept       = tx.pin_valid && tx.pin_ready;
    assign last_bit     = (cnt_q == LAST);

    // Advance one position toward the output end; vacated bit fills with 0.
    assign shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q <= tx.pin;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        cnt_q <= '0;
                        if (hold_full_q) begin
                            shift_q     <= hold_q;
                            hold_full_q <= 1'b0;
                        end else if (accept) begin
                            shift_q <= tx.pin;
                        end else begin
                            shift_q <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (accept) begin
                            hold_q      <= tx.pin;
                            hold_full_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx.sout       = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign tx.sout_valid = (state_q == SHIFT);
    assign tx.sout_last  = (state_q == SHIFT) && last_bit;
    assign tx.busy       = (state_q == SHIFT) || hold_full_q;
endmodule
